// File: rtl/adder_accumulator_pkg.sv
// adder_accumulator_pkg: shared state encoding and default widths for the accumulator slice
package adder_accumulator_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_COUNT_W = 8;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ACCUM = 2'd1;
  localparam state_t DONE = 2'd2;
endpackage

// File: rtl/adder_accumulator_if.sv
// adder_accumulator_if: start command, operand stream and result signals of the accumulator
interface adder_accumulator_if import adder_accumulator_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int COUNT_W = DEF_COUNT_W
);
  logic start;
  logic [COUNT_W-1:0] length;
  logic [WIDTH-1:0] operand;
  logic operand_valid;
  logic operand_ready;
  logic [WIDTH-1:0] sum;
  logic overflow;
  logic busy;
  logic done;
  modport master (output start, length, operand, operand_valid, input operand_ready, sum, overflow, busy, done);
  modport slave (input start, length, operand, operand_valid, output operand_ready, sum, overflow, busy, done);
endinterface

// File: rtl/adder_accumulator_ripple_carry_adder.sv
// ripple_carry_adder: WIDTH-bit unsigned adder built from a chain of full adders
module ripple_carry_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] number1,
  input  logic [WIDTH-1:0] number2,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);
  logic [WIDTH:0] c;
  assign c[0] = carry_in;
  assign carry_out = c[WIDTH];
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign result[i] = number1[i] ^ number2[i] ^ c[i];
    assign c[i+1] = (number1[i] & number2[i]) | (c[i] & (number1[i] ^ number2[i]));
  end
endmodule

// File: rtl/adder_accumulator.sv
// adder_accumulator: sums a counted operand stream through the ripple carry adder
// Define ACC_SATURATE_EN to clamp the sum at all ones on carry-out instead of wrapping.
module adder_accumulator import adder_accumulator_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input logic clk,
  input logic rst,
  adder_accumulator_if.slave bus
);
  state_t state;
  logic [COUNT_W-1:0] remaining;
  logic [WIDTH-1:0] acc, result, acc_next;
  logic ovf, carry, beat;
  ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
    .number1(acc),
    .number2(bus.operand),
    .carry_in(1'b0),
    .result(result),
    .carry_out(carry)
  );
`ifdef ACC_SATURATE_EN
  // once saturated, any further non-zero operand carries out again, so all ones sticks
  assign acc_next = carry ? '1 : result;
`else
  assign acc_next = result;
`endif
  assign beat = state == ACCUM && bus.operand_valid;
  assign bus.operand_ready = state == ACCUM;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.sum = acc;
  assign bus.overflow = ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      ovf <= 1'b0;
      remaining <= '0;
    end else if (state == IDLE && bus.start) begin
      acc <= '0;
      ovf <= 1'b0;
      remaining <= bus.length;
      state <= bus.length != '0 ? ACCUM : DONE;
    end else if (beat) begin
      acc <= acc_next;
      ovf <= ovf | carry;
      remaining <= remaining - COUNT_W'(1);
      if (remaining == COUNT_W'(1)) state <= DONE;
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_adder_accumulator.sv
// tb_adder_accumulator: randomized and directed runs checked against an arithmetic reference model
module tb_adder_accumulator;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_sum;
  logic exp_ov;
  logic [31:0] ops[$];
  bit vpat[$];
  adder_accumulator_if #(.WIDTH(32), .COUNT_W(8)) bus ();
  adder_accumulator #(.WIDTH(32), .COUNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic [31:0] op);
    longint s = longint'(exp_sum) + longint'(op);
    if (s > 64'hFFFF_FFFF) begin
      exp_ov = 1'b1;
`ifdef ACC_SATURATE_EN
      exp_sum = 32'hFFFF_FFFF;
`else
      exp_sum = 32'(s - 64'h1_0000_0000);
`endif
    end else exp_sum = 32'(s);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // one complete run of ops[]; valid follows vpat[] cyclically, else random gaps or back-to-back
  task automatic run(input bit gaps);
    int len = ops.size();
    int k = 0;
    int b = 0;
    int cyc = 0;
    bit v;
    exp_sum = '0;
    exp_ov = 1'b0;
    bus.start = 1'b1;
    bus.length = 8'(len);
    bus.operand_valid = 1'b0;
    tick();
    bus.start = 1'b0;
    bus.length = 8'($urandom);
    while (b < len) begin
      chk("ready_accum", bus.operand_ready, 1);
      chk("busy_accum", bus.busy, 1);
      chk("done_early", bus.done, 0);
      v = vpat.size() != 0 ? vpat[k % vpat.size()] : (gaps ? 1'($urandom) : 1'b1);
      k++;
      bus.operand_valid = v;
      bus.operand = v ? ops[b] : $urandom;
      bus.start = 1'($urandom);
      tick();
      if (v) begin
        model(ops[b]);
        b++;
      end
      chk("sum_beat", bus.sum, exp_sum);
      chk("ovf_beat", bus.overflow, exp_ov);
      cyc++;
      if (cyc > 2000) begin
        checks++;
        failures++;
        $error("FAIL timeout observed=%0d beats expected=%0d", b, len);
        break;
      end
    end
    bus.operand_valid = 1'b0;
    bus.start = 1'b1;
    chk("done_pulse", bus.done, 1);
    chk("ready_done", bus.operand_ready, 0);
    chk("busy_done", bus.busy, 1);
    chk("sum_done", bus.sum, exp_sum);
    chk("ovf_done", bus.overflow, exp_ov);
    tick();
    bus.start = 1'b0;
    chk("done_end", bus.done, 0);
    chk("busy_idle", bus.busy, 0);
    chk("ready_idle", bus.operand_ready, 0);
    tick();
    chk("sum_hold", bus.sum, exp_sum);
    chk("ovf_hold", bus.overflow, exp_ov);
  endtask
  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.length = '0;
    bus.operand = '0;
    bus.operand_valid = 1'b0;
    tick();
    tick();
    chk("rst_sum", bus.sum, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_ready", bus.operand_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;
    tick();
    ops.delete();
    ops.push_back(32'd5);
    ops.push_back(32'd7);
    ops.push_back(32'd9);
    run(1'b0);
    chk("sum_5_7_9", bus.sum, 21);
    chk("ovf_5_7_9", bus.overflow, 0);
    ops.delete();
    run(1'b0);
    chk("sum_len0", bus.sum, 0);
    ops.delete();
    ops.push_back(32'hFFFF_FFFF);
    ops.push_back(32'h2);
    run(1'b0);
`ifdef ACC_SATURATE_EN
    chk("sum_sat", bus.sum, 32'hFFFF_FFFF);
`else
    chk("sum_wrap", bus.sum, 32'h1);
`endif
    chk("ovf_wrap", bus.overflow, 1);
    ops.delete();
    for (int i = 0; i < 4; i++) ops.push_back(32'(100 * (i + 1)));
    vpat.delete();
    vpat.push_back(1'b1);
    vpat.push_back(1'b0);
    vpat.push_back(1'b0);
    vpat.push_back(1'b1);
    vpat.push_back(1'b1);
    vpat.push_back(1'b0);
    vpat.push_back(1'b1);
    run(1'b0);
    chk("sum_gaps", bus.sum, 1000);
    vpat.delete();
    bus.start = 1'b1;
    bus.length = 8'd5;
    tick();
    bus.start = 1'b0;
    bus.operand_valid = 1'b1;
    bus.operand = 32'd11;
    tick();
    tick();
    chk("sum_partial", bus.sum, 22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.operand_valid = 1'b0;
    chk("mid_rst_sum", bus.sum, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_ready", bus.operand_ready, 0);
    tick();
    chk("post_rst_done", bus.done, 0);
    ops.delete();
    for (int i = 0; i < 5; i++) ops.push_back($urandom_range(0, 1000));
    run(1'b1);
    for (int r = 0; r < 6; r++) begin
      ops.delete();
      for (int i = 0; i < int'($urandom_range(1, 20)); i++)
        ops.push_back($urandom_range(0, 3) == 0 ? (32'hF000_0000 | $urandom) : $urandom_range(0, 100000));
      run(1'b1);
    end
    ops.delete();
    for (int i = 0; i < 255; i++) ops.push_back($urandom_range(0, 65535));
    run(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adder_accumulator.md
# adder_accumulator

Sequential accumulation stage wrapped around the WIDTH-bit ripple carry adder. Accepts a start command with an operand count, takes operands over a valid/ready stream, feeds the running sum and each operand into the adder, and registers the adder's result and carry-out every accepted beat. Produces a final sum, a sticky overflow flag and a one-cycle done pulse for downstream consumers.

## Interface
- WIDTH, 32, operand/sum width, passed to the adder
- COUNT_W, 8, width of the operand-count field
- Clk_i  input  1  clock, all state updates on rising edge
- Rst_i  input  1  synchronous, active-high reset
- Start_i  input  1  begin a new accumulation; sampled only in IDLE
- Length_i  input  COUNT_W  operand count for the run; sampled with Start_i
- Operand_i  input  WIDTH  operand data
- OperandValid_i  input  1  Operand_i valid
- OperandReady_o  output  1  block accepts an operand this cycle
- Sum_o  output  WIDTH  accumulator register, driven continuously
- Overflow_o  output  1  sticky, set by any adder carry-out during the run
- Busy_o  output  1  high in ACCUM and DONE
- Done_o  output  1  one-cycle pulse, run complete

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: OperandReady_o=0. On Start_i: acc<=0, Overflow<=0, remaining<=Length_i; next state ACCUM if Length_i!=0, else DONE.
- ACCUM: OperandReady_o=1. Beat accepted when OperandValid_i & OperandReady_o. On a beat: adder inputs Number1=acc, Number2=Operand_i, Carry_i=0; acc<=Result, Overflow<=Overflow|Carry_o, remaining<=remaining-1. Beat with remaining==1 moves to DONE. No beat: hold all state.
- DONE: Done_o=1 for exactly this cycle; OperandReady_o=0; next state IDLE unconditionally.
- Start_i ignored in ACCUM and DONE; Length_i ignored except with an accepted Start_i.
- Sum_o and Overflow_o hold their final values through IDLE until the next accepted Start_i.
- Arithmetic: unsigned, modulo 2^WIDTH unless saturation is compiled in (see Configuration).
- Length_i=0: zero-operand run, Sum_o=0, Overflow_o=0, Done_o pulses.
- Maximum run: 2^COUNT_W-1 operands.

## Timing
- Reset values: state IDLE, Sum_o=0, Overflow_o=0, OperandReady_o=0, Busy_o=0, Done_o=0, remaining=0.
- Rst_i asserted in any state, including mid-run: all of the above on the next edge. Partial sum discarded. No Done_o.
- Start_i accepted at edge t: OperandReady_o high from cycle t+1.
- N operands presented back-to-back: last beat at edge t+N, Done_o high in cycle t+N+1, IDLE at t+N+2.
- Length_i=0: Done_o high in cycle t+1.
- Sum_o reflects each accepted operand one cycle after the accepting edge. The adder path is combinational from acc and Operand_i to the acc register, one adder delay per cycle.
- OperandValid_i gaps stretch the run by the gap length. Done timing stays relative to the last beat.

## Configuration
- ACC_SATURATE_EN defined: a beat whose carry-out is 1 loads acc with all ones. Further beats keep all ones, including beats with carry-out 0. Overflow_o set as usual.
- ACC_SATURATE_EN undefined: acc wraps modulo 2^WIDTH. Overflow_o still records the wrap.

## Structure
- Shared package: state encoding typedef (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) and default WIDTH/COUNT_W constants.
- One sub-module: ripple_carry_adder instantiated with WIDTH, Carry_i tied to 0.
- Control FSM, counter and accumulator register live in the top module.

## Test plan
- Reset then Start_i, Length_i=3, operands 5, 7, 9 back-to-back: Sum_o=21, Overflow_o=0, Done_o one cycle at t+4.
- Length_i=0: Done_o at t+1, Sum_o=0, OperandReady_o never high.
- WIDTH=32, operands 0xFFFF_FFFF then 0x2: wrap build gives Sum_o=0x1 with Overflow_o=1. ACC_SATURATE_EN build gives Sum_o=0xFFFF_FFFF with Overflow_o=1.
- Length_i=4 with OperandValid_i toggling 1,0,0,1,1,0,1: exactly 4 beats counted, Done_o follows the 4th beat by one cycle, Sum_o correct.
- Rst_i asserted after 2 of 5 beats: next cycle Sum_o=0, Busy_o=0, no Done_o. A fresh Start_i runs normally.
- Start_i pulsed during ACCUM and DONE: ignored, and the run result is unchanged.
